// File: rtl/riscv_pkg.sv
// Shared core definitions: RV32 major opcodes, halt FSM encoding, default halt words.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] DEF_HALT_INST0 = 32'h00008067;
    localparam logic [31:0] DEF_HALT_INST1 = 32'h00c00093;

    typedef enum logic [1:0] {
        HS_RUN    = 2'd0,
        HS_ARMED  = 2'd1,
        HS_HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/riscv_halt_detect.sv
// Halt-sequence detector: tracks HALT_INST0 followed by HALT_INST1 across retired instructions.
// Latency 1 (halted registered); no backpressure, valid is a pure strobe.
// HALTED is terminal until RSTn; bubbles never break an armed sequence.
module riscv_halt_detect
    import riscv_pkg::*;
#(
    parameter logic [31:0] HALT_INST0 = DEF_HALT_INST0,
    parameter logic [31:0] HALT_INST1 = DEF_HALT_INST1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        valid,
    input  logic [31:0] inst,
    output logic        halted
);

    halt_state_t state, state_nxt;

    always_ff @(posedge CLK) begin
        if (!RSTn) state <= HS_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (valid) begin
            case (state)
                HS_RUN: begin
                    if (inst == HALT_INST0) state_nxt = HS_ARMED;
                end
                HS_ARMED: begin
                    if (inst == HALT_INST1)      state_nxt = HS_HALTED;
                    else if (inst == HALT_INST0) state_nxt = HS_ARMED;
                    else                         state_nxt = HS_RUN;
                end
                HS_HALTED: state_nxt = HS_HALTED;
                default:   state_nxt = HS_RUN;
            endcase
        end
    end

    assign halted = (state == HS_HALTED);

endmodule

// File: rtl/riscv_retire_unit.sv
// Retirement observation port: instruction count, visible result mux and halt detection.
// Latency 1 (all outputs registered); no backpressure, one retire per cycle accepted.
// Once halted, RET_VALID is ignored and every output freezes until RSTn.
module riscv_retire_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] HALT_INST0 = DEF_HALT_INST0,
    parameter logic [31:0] HALT_INST1 = DEF_HALT_INST1,
    parameter int          CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             RET_VALID,
    input  logic [31:0]      RET_INST,
    input  logic [31:0]      RET_RD_DATA,
    input  logic [31:0]      RET_MEM_ADDR,
    input  logic             RET_BR_TAKEN,
    output logic [CNT_W-1:0] NUM_INST,
    output logic [31:0]      OUTPUT_PORT,
    output logic             HALT
);

    logic        halted;
    logic        accept;
    logic        out_upd;
    logic [31:0] out_nxt;

    riscv_halt_detect #(
        .HALT_INST0 (HALT_INST0),
        .HALT_INST1 (HALT_INST1)
    ) u_halt_detect (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .valid  (accept),
        .inst   (RET_INST),
        .halted (halted)
    );

    assign accept = RET_VALID & RSTn & ~halted;
    assign HALT   = halted;

    // Opcodes without an architecturally visible result leave the port untouched.
    always_comb begin
        out_upd = 1'b1;
        out_nxt = RET_RD_DATA;
        case (RET_INST[6:0])
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_LOAD, OPC_JAL, OPC_JALR: out_nxt = RET_RD_DATA;
            OPC_STORE:                   out_nxt = RET_MEM_ADDR;
            OPC_BRANCH:                  out_nxt = {31'b0, RET_BR_TAKEN};
            default:                     out_upd = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            NUM_INST    <= '0;
            OUTPUT_PORT <= '0;
        end else if (accept) begin
            NUM_INST <= NUM_INST + CNT_W'(1);
            if (out_upd) OUTPUT_PORT <= out_nxt;
        end
    end

endmodule

// File: tb/tb_riscv_retire_unit.sv
// Directed scoreboard bench for riscv_retire_unit (CNT_W=4 so counter wrap is reachable).
module tb_riscv_retire_unit;
    import riscv_pkg::*;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          RET_VALID = 1'b0;
    logic [31:0]   RET_INST = '0;
    logic [31:0]   RET_RD_DATA = '0;
    logic [31:0]   RET_MEM_ADDR = '0;
    logic          RET_BR_TAKEN = 1'b0;
    logic [CW-1:0] NUM_INST;
    logic [31:0]   OUTPUT_PORT;
    logic          HALT;

    typedef struct {
        logic [CW-1:0] num;
        logic [31:0]   out;
        logic          halt;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    riscv_retire_unit #(
        .HALT_INST0 (32'h00008067),
        .HALT_INST1 (32'h00c00093),
        .CNT_W      (CW)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .RET_VALID    (RET_VALID),
        .RET_INST     (RET_INST),
        .RET_RD_DATA  (RET_RD_DATA),
        .RET_MEM_ADDR (RET_MEM_ADDR),
        .RET_BR_TAKEN (RET_BR_TAKEN),
        .NUM_INST     (NUM_INST),
        .OUTPUT_PORT  (OUTPUT_PORT),
        .HALT         (HALT)
    );

    always #5 CLK = ~CLK;

    localparam logic [31:0] ADDI = 32'h0f000093;
    localparam logic [31:0] SW   = 32'h00a12023;
    localparam logic [31:0] BGE  = 32'h00b55463;
    localparam logic [31:0] LUI  = 32'h123450b7;
    localparam logic [31:0] FNC  = 32'h0000000f;
    localparam logic [31:0] H0   = 32'h00008067;
    localparam logic [31:0] H1   = 32'h00c00093;

    // Drive one cycle of inputs at negedge and queue the outputs expected after the next posedge.
    task automatic step(input string tag, input logic rstn, input logic v,
                        input logic [31:0] inst, input logic [31:0] rd,
                        input logic [31:0] addr, input logic br,
                        input logic [CW-1:0] en, input logic [31:0] eo, input logic eh);
        exp_t e;
        @(negedge CLK);
        RSTn         = rstn;
        RET_VALID    = v;
        RET_INST     = inst;
        RET_RD_DATA  = rd;
        RET_MEM_ADDR = addr;
        RET_BR_TAKEN = br;
        e.num = en; e.out = eo; e.halt = eh; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: every posedge, compare the registered outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total += 3;
                if (NUM_INST !== e.num) begin
                    bad++;
                    $display("FAIL %s num_inst got=%0d exp=%0d", e.tag, NUM_INST, e.num);
                end
                if (OUTPUT_PORT !== e.out) begin
                    bad++;
                    $display("FAIL %s output_port got=%h exp=%h", e.tag, OUTPUT_PORT, e.out);
                end
                if (HALT !== e.halt) begin
                    bad++;
                    $display("FAIL %s halt got=%b exp=%b", e.tag, HALT, e.halt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        step("rst0", 0, 0, 0, 0, 0, 0, 4'd0, 32'h0, 0);
        step("rst1", 0, 1, ADDI, 32'h77, 0, 0, 4'd0, 32'h0, 0);
        step("addi", 1, 1, ADDI, 32'h0f00, 0, 0, 4'd1, 32'h0f00, 0);
        step("sw",   1, 1, SW, 32'hdead, 32'h0eec, 0, 4'd2, 32'h0eec, 0);
        step("bge",  1, 1, BGE, 32'hbeef, 32'h4, 1, 4'd3, 32'h1, 0);
        for (int i = 0; i < 3; i++)
            step("bubble", 1, 0, ADDI, 32'h1234, 32'h5678, 1, 4'd3, 32'h1, 0);
        step("addi2",  1, 1, ADDI, 32'h22, 0, 0, 4'd4, 32'h22, 0);
        step("bub2",   1, 0, H0, 32'h9, 0, 0, 4'd4, 32'h22, 0);
        step("lui",    1, 1, LUI, 32'h12345000, 0, 0, 4'd5, 32'h12345000, 0);
        step("fence",  1, 1, FNC, 32'h99, 32'h98, 1, 4'd6, 32'h12345000, 0);
        step("brk_h0", 1, 1, H0, 32'h100, 0, 0, 4'd7, 32'h100, 0);
        step("brk_ad", 1, 1, ADDI, 32'h5, 0, 0, 4'd8, 32'h5, 0);
        step("brk_h1", 1, 1, H1, 32'hc, 0, 0, 4'd9, 32'hc, 0);
        step("h0a",    1, 1, H0, 32'h200, 0, 0, 4'd10, 32'h200, 0);
        step("h0b",    1, 1, H0, 32'h204, 0, 0, 4'd11, 32'h204, 0);
        step("armbub", 1, 0, ADDI, 32'h1, 0, 0, 4'd11, 32'h204, 0);
        step("h1",     1, 1, H1, 32'hc, 0, 0, 4'd12, 32'hc, 1);
        step("frz0",   1, 1, ADDI, 32'h55, 0, 0, 4'd12, 32'hc, 1);
        step("frz1",   1, 1, SW, 32'h55, 32'h55, 0, 4'd12, 32'hc, 1);
        step("rsthlt", 0, 1, ADDI, 32'h55, 0, 0, 4'd0, 32'h0, 0);
        step("run",    1, 1, H1, 32'h3, 0, 0, 4'd1, 32'h3, 0);
        step("arm",    1, 1, H0, 32'h4, 0, 0, 4'd2, 32'h4, 0);
        step("rstarm", 0, 0, 0, 0, 0, 0, 4'd0, 32'h0, 0);
        step("noarm",  1, 1, H1, 32'h6, 0, 0, 4'd1, 32'h6, 0);
        step("rstw",   0, 0, 0, 0, 0, 0, 4'd0, 32'h0, 0);
        for (int i = 0; i < 15; i++)
            step("wrapfill", 1, 1, ADDI, 32'(i), 0, 0, 4'(i + 1), 32'(i), 0);
        step("wrap",   1, 1, ADDI, 32'h77, 0, 0, 4'd0, 32'h77, 0);
        step("post",   1, 1, BGE, 0, 0, 0, 4'd1, 32'h0, 0);
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge CLK);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
